// File: rtl/chess_vga_pkg.sv
// Shared constants for the chess VGA system: display timing, board RAM geometry,
// piece codes and the board-update arbiter state encoding.
package chess_vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 525;

    localparam int BOARD_ADDR_W = 6;
    localparam int BOARD_DATA_W = 4;

    // Low three bits select the piece kind, bit 3 marks a black piece.
    localparam logic [3:0] PIECE_EMPTY  = 4'h0;
    localparam logic [3:0] PIECE_PAWN   = 4'h1;
    localparam logic [3:0] PIECE_KNIGHT = 4'h2;
    localparam logic [3:0] PIECE_BISHOP = 4'h3;
    localparam logic [3:0] PIECE_ROOK   = 4'h4;
    localparam logic [3:0] PIECE_QUEEN  = 4'h5;
    localparam logic [3:0] PIECE_KING   = 4'h6;
    localparam logic [3:0] PIECE_BLACK  = 4'h8;

    typedef enum logic [1:0] {
        ST_DISPLAY = 2'd0,
        ST_WINDOW  = 2'd1,
        ST_HOLD    = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first unmasked request at or after the pointer wins;
// the pointer moves past the winner only when the caller accepts the grant.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    input  logic             advance,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any_gnt
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0] elig;

    assign elig = req & ~mask;

    always_comb begin : pick
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] idx;
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(N_REQ)) begin
                sum = sum - (IDX_W+1)'(N_REQ);
            end
            idx = sum[IDX_W-1:0];
            if (!any_gnt && elig[idx]) begin
                any_gnt  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && any_gnt) begin
            ptr_d = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/board_update_arbiter.sv
// Shares the board RAM write port among N_REQ requesters, granting writes only
// inside the vertical blanking window with a per-frame write budget.
module board_update_arbiter
    import chess_vga_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int ADDR_W         = BOARD_ADDR_W,
    parameter int DATA_W         = BOARD_DATA_W,
    parameter int WIN_START_LINE = 480,
    parameter int WIN_END_LINE   = 524,
    parameter int MAX_WR         = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [9:0]                vcount,
    input  logic [9:0]                hcount,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          ack,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic                      frame_tick,
    output logic                      budget_hit
);

    localparam int               IDX_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int               CNT_W       = $clog2(MAX_WR + 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(MAX_WR);
    localparam logic [9:0]       WIN_START_V = 10'(WIN_START_LINE);
    localparam logic [9:0]       WIN_END_V   = 10'(WIN_END_LINE);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              frame_tick_q, frame_tick_d;

    logic              win_open;
    logic              grant_en;
    logic [N_REQ-1:0]  gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              any_gnt;

    // The window is line-based; the pixel position never affects a decision.
    logic unused_hcount;
    assign unused_hcount = ^hcount;

    assign win_open = (vcount >= WIN_START_V) && (vcount <= WIN_END_V);

    // Masking with the in-flight ack stops a level request being granted twice.
    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .clk     (clk),
        .rst_n   (rst),
        .req     (req),
        .mask    (ack_q),
        .advance (grant_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        frame_tick_d = 1'b0;
        grant_en     = 1'b0;
        case (state_q)
            ST_DISPLAY: begin
                if (win_open) begin
                    state_d      = ST_WINDOW;
                    frame_tick_d = 1'b1;
                    cnt_d        = '0;
                end
            end
            ST_WINDOW: begin
                if (!win_open) begin
                    state_d = ST_DISPLAY;
                end else if (any_gnt) begin
                    grant_en = 1'b1;
                    cnt_d    = sat_inc(cnt_q);
                    if (cnt_d == CNT_MAX) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!win_open) begin
                    state_d = ST_DISPLAY;
                end
            end
            default: state_d = ST_DISPLAY;
        endcase
    end

    always_comb begin
        ack_d     = grant_en ? gnt : '0;
        wr_en_d   = grant_en;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (grant_en) begin
            wr_addr_d = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
            wr_data_d = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_DISPLAY;
            cnt_q        <= '0;
            ack_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ack_q        <= ack_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign ack        = ack_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_tick = frame_tick_q;
    assign budget_hit = (state_q == ST_HOLD);

endmodule

// File: tb/tb_board_update_arbiter.sv
// Directed bench for board_update_arbiter: expected writes are queued when the
// stimulus that causes them is applied and popped when the write appears.
module tb_board_update_arbiter;

    localparam int N  = 4;
    localparam int AW = 6;
    localparam int DW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [9:0]      vcount, hcount;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    ack;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            frame_tick;
    logic            budget_hit;

    typedef struct packed {
        logic [N-1:0]  ack;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           sb[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [AW-1:0] a_tab [N];
    logic [DW-1:0] d_tab [N];

    board_update_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .vcount     (vcount),
        .hcount     (hcount),
        .req        (req),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .ack        (ack),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_tick (frame_tick),
        .budget_hit (budget_hit)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int i);
        wr_t e;
        e.ack    = '0;
        e.ack[i] = 1'b1;
        e.addr   = a_tab[i];
        e.data   = d_tab[i];
        sb.push_back(e);
    endtask

    task automatic expect_write(input string tag);
        wr_t e;
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        chk(tag, {wr_en, ack, wr_addr, wr_data}, {1'b1, e.ack, e.addr, e.data});
    endtask

    task automatic expect_idle(input string tag);
        chk(tag, {wr_en, ack}, '0);
    endtask

    initial begin
        a_tab[0] = 6'd3;  d_tab[0] = 4'd9;
        a_tab[1] = 6'd17; d_tab[1] = 4'd2;
        a_tab[2] = 6'd12; d_tab[2] = 4'd5;
        a_tab[3] = 6'd63; d_tab[3] = 4'd15;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = a_tab[i];
            req_data[i*DW +: DW] = d_tab[i];
        end
        rst    = 1'b0;
        vcount = 10'd0;
        hcount = 10'd0;
        req    = '0;

        repeat (3) tick();
        chk("rst_ack", ack, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_frame_tick", frame_tick, 0);
        chk("rst_budget_hit", budget_hit, 0);
        rst = 1'b1;

        // Single request waits through display, served right after frame_tick.
        vcount = 10'd100;
        req    = 4'b0100;
        repeat (2) begin
            tick();
            expect_idle("display_idle");
        end
        vcount = 10'd480;
        tick();
        chk("ft_first", frame_tick, 1);
        expect_idle("ft_no_write");
        push(2);
        tick();
        expect_write("req2_write");
        chk("ft_one_cycle", frame_tick, 0);
        req = '0;
        tick();
        expect_idle("req2_done");

        // All four requesting: pointer sits at 3, one write per cycle in rotation.
        req = 4'b1111;
        for (int k = 0; k < 9; k++) begin
            push((3 + k) % N);
            tick();
            expect_write($sformatf("rr_%0d", k));
        end
        vcount = 10'd0;
        tick();
        expect_idle("closed_no_grant");
        req = '0;

        // One continuous requester: 32 writes two cycles apart, then HOLD.
        req    = 4'b0001;
        vcount = 10'd480;
        tick();
        chk("ft_budget_frame", frame_tick, 1);
        expect_idle("budget_ft_idle");
        for (int k = 0; k < 32; k++) begin
            push(0);
            tick();
            expect_write($sformatf("budget_wr_%0d", k));
            if (k == 30) chk("budget_not_yet", budget_hit, 0);
            if (k == 31) chk("budget_hit_set", budget_hit, 1);
            tick();
            expect_idle($sformatf("budget_gap_%0d", k));
        end
        repeat (3) begin
            tick();
            expect_idle("hold_idle");
            chk("hold_budget", budget_hit, 1);
        end
        vcount = 10'd0;
        tick();
        chk("hold_released", budget_hit, 0);
        expect_idle("hold_release_idle");
        vcount = 10'd480;
        tick();
        chk("ft_next_frame", frame_tick, 1);
        push(0);
        tick();
        expect_write("next_frame_wr0");
        chk("cnt_restart_a", budget_hit, 0);
        tick();
        expect_idle("next_frame_gap");
        push(0);
        tick();
        expect_write("next_frame_wr1");
        chk("cnt_restart_b", budget_hit, 0);
        req = '0;
        tick();
        expect_idle("next_frame_done");

        // Grant decided on the very last open cycle still completes.
        vcount = 10'd524;
        hcount = 10'd799;
        req    = 4'b0010;
        push(1);
        tick();
        expect_write("last_cycle_grant");
        vcount = 10'd0;
        hcount = 10'd0;
        req    = 4'b1000;
        tick();
        expect_idle("line0_no_grant");
        vcount = 10'd100;
        repeat (3) begin
            tick();
            expect_idle("req3_waits");
        end
        vcount = 10'd480;
        tick();
        chk("ft_req3_frame", frame_tick, 1);
        push(3);
        tick();
        expect_write("req3_served");
        req = '0;
        tick();
        expect_idle("req3_done");

        // Request withdrawn during display is never acknowledged.
        vcount = 10'd100;
        tick();
        expect_idle("pulse_pre");
        req = 4'b0010;
        tick();
        expect_idle("pulse_hi");
        req = '0;
        tick();
        expect_idle("pulse_lo");
        vcount = 10'd480;
        tick();
        chk("ft_pulse_frame", frame_tick, 1);
        repeat (4) begin
            tick();
            expect_idle("pulse_dropped");
        end

        // Asynchronous reset mid-window clears outputs and the RR pointer.
        vcount = 10'd490;
        req    = 4'b1111;
        push(0);
        tick();
        expect_write("pre_reset_write");
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_outputs", {ack, wr_en, frame_tick, budget_hit, wr_addr, wr_data}, 0);
        tick();
        rst = 1'b1;
        tick();
        chk("ft_after_reset", frame_tick, 1);
        expect_idle("after_reset_idle");
        push(0);
        tick();
        expect_write("after_reset_req0");
        req = '0;
        tick();
        expect_idle("final_idle");

        chk("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
